// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide datapath and its control-unit requester.
package mult_div_pkg;

  localparam int unsigned MD_WIDTH   = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  // MDControl op encodings
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Request attributes captured when an operation is accepted
  typedef struct packed {
    logic op;
    logic sign_a;
    logic sign_b;
  } md_req_t;

endpackage

// File: rtl/mult_div_abs.sv
// Sign/magnitude split: sign is the MSB; output is the input, sign-extended by one bit,
// optionally negated (invert + 1). Used for operand magnitudes and for result sign fix-up.
module mult_div_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic         o_sign,
  output logic [W:0]   o_mag
);

  logic [W:0] w_ext;

  assign o_sign = i_val[W-1];
  assign w_ext  = {i_val[W-1], i_val};

  // Conditional two's complement negation
  assign o_mag = i_neg ? ((~w_ext) + (W+1)'(1)) : w_ext;

endmodule

// File: rtl/mult_div.sv
// Sequential signed multiply/divide: one bit per cycle on magnitudes, sign fix-up in FIX.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned PW = 2 * WIDTH;

  // Registered state
  md_state_t        r_state,  r_state_nxt;
  md_req_t          r_req,    r_req_nxt;
  logic [CNT_W-1:0] r_cnt,    r_cnt_nxt;
  logic [WIDTH:0]   r_mcand,  r_mcand_nxt;
  logic [WIDTH:0]   r_div,    r_div_nxt;
  logic [PW-1:0]    r_acc,    r_acc_nxt;
  logic [WIDTH-1:0] r_quo,    r_quo_nxt;
  logic [WIDTH-1:0] r_rem,    r_rem_nxt;
  logic [WIDTH-1:0] r_hi,     r_hi_nxt;
  logic [WIDTH-1:0] r_lo,     r_lo_nxt;
  logic             r_busy,   r_busy_nxt;
  logic             r_done,   r_done_nxt;
  logic             r_dz,     r_dz_nxt;
  logic             r_dz_pend, r_dz_pend_nxt;

  // Operand magnitudes
  logic             w_sign_a, w_sign_b;
  logic [WIDTH:0]   w_mag_a,  w_mag_b;

  mult_div_abs #(.W(WIDTH)) u_abs_a (
    .i_val  (a),
    .i_neg  (a[WIDTH-1]),
    .o_sign (w_sign_a),
    .o_mag  (w_mag_a)
  );

  mult_div_abs #(.W(WIDTH)) u_abs_b (
    .i_val  (b),
    .i_neg  (b[WIDTH-1]),
    .o_sign (w_sign_b),
    .o_mag  (w_mag_b)
  );

  // Result sign fix-up in FIX
  logic             w_neg_res;
  logic             w_fs_p, w_fs_q, w_fs_r;
  logic [PW:0]      w_prod_fix;
  logic [WIDTH:0]   w_quo_fix;
  logic [WIDTH:0]   w_rem_fix;

  assign w_neg_res = r_req.sign_a ^ r_req.sign_b;

  mult_div_abs #(.W(PW)) u_fix_prod (
    .i_val  (r_acc),
    .i_neg  (w_neg_res),
    .o_sign (w_fs_p),
    .o_mag  (w_prod_fix)
  );

  mult_div_abs #(.W(WIDTH)) u_fix_quo (
    .i_val  (r_quo),
    .i_neg  (w_neg_res),
    .o_sign (w_fs_q),
    .o_mag  (w_quo_fix)
  );

  // Remainder follows the sign of the dividend
  mult_div_abs #(.W(WIDTH)) u_fix_rem (
    .i_val  (r_rem),
    .i_neg  (r_req.sign_a),
    .o_sign (w_fs_r),
    .o_mag  (w_rem_fix)
  );

  // Iteration datapath
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_sum   = (WIDTH+1)'(r_acc[PW-1:WIDTH]) + (r_acc[0] ? r_mcand : '0);
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - r_div;
  assign w_ge    = (w_shift >= r_div);

  // Bits intentionally left unread
  logic w_unused;
  assign w_unused = ^{w_fs_p, w_fs_q, w_fs_r, w_prod_fix[PW], w_quo_fix[WIDTH],
                      w_rem_fix[WIDTH], w_diff[WIDTH]};

  // Next-state and next-output logic
  always_comb begin
    r_state_nxt   = r_state;
    r_req_nxt     = r_req;
    r_cnt_nxt     = r_cnt;
    r_mcand_nxt   = r_mcand;
    r_div_nxt     = r_div;
    r_acc_nxt     = r_acc;
    r_quo_nxt     = r_quo;
    r_rem_nxt     = r_rem;
    r_hi_nxt      = r_hi;
    r_lo_nxt      = r_lo;
    r_busy_nxt    = r_busy;
    r_done_nxt    = 1'b0;
    r_dz_nxt      = 1'b0;
    r_dz_pend_nxt = 1'b0;

    if (r_dz_pend) begin
      r_done_nxt = 1'b1;
      r_dz_nxt   = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          r_req_nxt = '{op: op, sign_a: w_sign_a, sign_b: w_sign_b};
          r_cnt_nxt = '0;
          if ((op == MD_DIV) && (b == '0)) begin
            r_dz_pend_nxt = 1'b1;
          end else begin
            r_state_nxt = ST_RUN;
            r_busy_nxt  = 1'b1;
            r_mcand_nxt = w_mag_a;
            r_div_nxt   = w_mag_b;
            r_rem_nxt   = '0;
            if (op == MD_MULT) begin
              r_acc_nxt = {{WIDTH{1'b0}}, w_mag_b[WIDTH-1:0]};
            end else begin
              r_quo_nxt = w_mag_a[WIDTH-1:0];
            end
          end
        end
      end

      ST_RUN: begin
        if (r_req.op == MD_MULT) begin
          r_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end else begin
          r_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
        end
        r_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
          r_state_nxt = ST_FIX;
        end
      end

      ST_FIX: begin
        if (r_req.op == MD_MULT) begin
          r_hi_nxt = w_prod_fix[PW-1:WIDTH];
          r_lo_nxt = w_prod_fix[WIDTH-1:0];
        end else begin
          r_hi_nxt = w_rem_fix[WIDTH-1:0];
          r_lo_nxt = w_quo_fix[WIDTH-1:0];
        end
        r_done_nxt  = 1'b1;
        r_busy_nxt  = 1'b0;
        r_state_nxt = ST_IDLE;
      end

      default: begin
        r_state_nxt = ST_IDLE;
        r_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_div     <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      r_state   <= r_state_nxt;
      r_req     <= r_req_nxt;
      r_cnt     <= r_cnt_nxt;
      r_mcand   <= r_mcand_nxt;
      r_div     <= r_div_nxt;
      r_acc     <= r_acc_nxt;
      r_quo     <= r_quo_nxt;
      r_rem     <= r_rem_nxt;
      r_hi      <= r_hi_nxt;
      r_lo      <= r_lo_nxt;
      r_busy    <= r_busy_nxt;
      r_done    <= r_done_nxt;
      r_dz      <= r_dz_nxt;
      r_dz_pend <= r_dz_pend_nxt;
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: hand-computed products, quotients, div-by-zero, ignore and abort.
module tb_mult_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_pass;
  int n_total;
  int cyc;
  int bcnt;
  int done_seen;

  mult_div #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one request; optionally pulse a second start at edge inj_at or assert reset at edge rst_at
  task automatic run_op(input logic t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input int inj_at, input int rst_at,
                        output int o_cyc, output int o_bcnt);
    int  k;
    bit  fin;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    start = 1'b1;
    k     = 0;
    fin   = 1'b0;
    o_bcnt = 0;
    while (!fin && k < 100) begin
      @(posedge clock);
      #1;
      k++;
      start = 1'b0;
      if (busy) o_bcnt++;
      if (done) fin = 1'b1;
      if (k == inj_at) begin
        start = 1'b1;
        op    = ~t_op;
        a     = 32'h64;
        b     = 32'h64;
      end
      if (k == rst_at) begin
        reset = 1'b1;
        fin   = 1'b1;
      end
    end
    o_cyc = k - 1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_dz", 64'(div_zero), 64'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0, cyc, bcnt);
    check("mul1_latency", 64'(cyc), 64'd33);
    check("mul1_busy_cycles", 64'(bcnt), 64'd33);
    check("mul1_done", 64'(done), 64'h1);
    check("mul1_dz", 64'(div_zero), 64'h0);
    check("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mul1_lo", 64'(lo), 64'hFFFF_FFEB);
    @(posedge clock);
    #1;
    check("mul1_done_pulse", 64'(done), 64'h0);

    // (-2^31)^2 = 2^62
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, cyc, bcnt);
    check("mul2_hi", 64'(hi), 64'h4000_0000);
    check("mul2_lo", 64'(lo), 64'h0);

    // -1 * -1 = 1, started in the done cycle of the previous op
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, cyc, bcnt);
    check("mul3_latency", 64'(cyc), 64'd33);
    check("mul3_hi", 64'(hi), 64'h0);
    check("mul3_lo", 64'(lo), 64'h1);

    // -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, cyc, bcnt);
    check("div1_latency", 64'(cyc), 64'd33);
    check("div1_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div1_hi", 64'(hi), 64'hFFFF_FFFF);

    // 7 / -2 = -3 rem 1
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, cyc, bcnt);
    check("div2_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div2_hi", 64'(hi), 64'h1);

    // Overflow case
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, cyc, bcnt);
    check("div3_lo", 64'(lo), 64'h8000_0000);
    check("div3_hi", 64'(hi), 64'h0);
    check("div3_dz", 64'(div_zero), 64'h0);

    // 0x451 / 0x20 = 0x22 rem 0x11 (sets up hi/lo for the divide-by-zero case)
    run_op(1'b1, 32'h451, 32'h20, 0, 0, cyc, bcnt);
    check("div4_lo", 64'(lo), 64'h22);
    check("div4_hi", 64'(hi), 64'h11);
    @(posedge clock);
    #1;

    // Divide by zero
    op    = 1'b1;
    a     = 32'd5;
    b     = 32'd0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("dz_e0_done", 64'(done), 64'h0);
    check("dz_e0_busy", 64'(busy), 64'h0);
    @(posedge clock);
    #1;
    check("dz_e1_done", 64'(done), 64'h1);
    check("dz_e1_flag", 64'(div_zero), 64'h1);
    check("dz_e1_busy", 64'(busy), 64'h0);
    check("dz_hi_kept", 64'(hi), 64'h11);
    check("dz_lo_kept", 64'(lo), 64'h22);
    @(posedge clock);
    #1;
    check("dz_e2_done", 64'(done), 64'h0);
    check("dz_e2_flag", 64'(div_zero), 64'h0);

    // 3 * 5 with a second start (DIV 100/100) pulsed mid-run
    run_op(1'b0, 32'd3, 32'd5, 10, 0, cyc, bcnt);
    check("ign_latency", 64'(cyc), 64'd33);
    check("ign_hi", 64'(hi), 64'h0);
    check("ign_lo", 64'(lo), 64'd15);
    @(posedge clock);
    #1;
    check("ign_no_requeue", 64'(busy), 64'h0);

    // Abort with reset mid-run
    run_op(1'b0, 32'd9, 32'd9, 0, 20, cyc, bcnt);
    check("abort_busy_before", 64'(bcnt), 64'd20);
    #1;
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'h0);

    // Fresh operation after abort
    run_op(1'b0, 32'd6, 32'hFFFF_FFF9, 0, 0, cyc, bcnt);
    check("post_latency", 64'(cyc), 64'd33);
    check("post_hi", 64'(hi), 64'hFFFF_FFFF);
    check("post_lo", 64'(lo), 64'hFFFF_FFD6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
